// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE   = 2'd0,
        SW_RUN    = 2'd1,
        SW_PAUSED = 2'd2,
        SW_MAXED  = 2'd3
    } sw_state_t;

    localparam int SEC_MAX = 59;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control/display bundle between the button/divider logic and the stopwatch core.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic             en;
    logic             clk1k;
    logic             start;
    logic             stop;
    logic             clear;
    logic             lap;
    logic [MIN_W-1:0] minutes;
    logic [SEC_W-1:0] seconds;
    logic             running;
    logic             lap_active;

    modport master (
        output en, clk1k, start, stop, clear, lap,
        input  minutes, seconds, running, lap_active
    );

    modport slave (
        input  en, clk1k, start, stop, clear, lap,
        output minutes, seconds, running, lap_active
    );

endinterface

// File: rtl/stopwatch_counter_rise_detect.sv
// Single-flop rising-edge detector; history updates every cycle regardless of enable.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q_reg <= 1'b0;
        end else begin
            d_q_reg <= d;
        end
    end

    assign rise = d & ~d_q_reg;

endmodule

// File: rtl/stopwatch_counter.sv
// Count-up stopwatch core: start/stop/clear FSM with cascaded ms/sec/min counters.
// Define STOPWATCH_LAP_EN to build the lap-hold display freeze.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int MAX_MIN       = 59
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_counter_if.slave  bus
);

    localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

`ifdef STOPWATCH_LAP_EN
    localparam int N_EV = 5;
`else
    localparam int N_EV = 4;
`endif

    logic [N_EV-1:0] ev_in;
    logic [N_EV-1:0] ev_rise;

    assign ev_in[0] = bus.clk1k;
    assign ev_in[1] = bus.start;
    assign ev_in[2] = bus.stop;
    assign ev_in[3] = bus.clear;
`ifdef STOPWATCH_LAP_EN
    assign ev_in[4] = bus.lap;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_EV; gi++) begin : g_rise
            rise_detect u_rise (
                .clk  (clk),
                .rst  (rst),
                .d    (ev_in[gi]),
                .rise (ev_rise[gi])
            );
        end
    endgenerate

    logic tick_ev, start_ev, stop_ev, clear_ev;
    assign tick_ev  = ev_rise[0];
    assign start_ev = ev_rise[1];
    assign stop_ev  = ev_rise[2];
    assign clear_ev = ev_rise[3];

    sw_state_t        state_reg;
    logic [MS_W-1:0]  ms_reg;
    logic [SEC_W-1:0] sec_reg;
    logic [MIN_W-1:0] min_reg;
    logic             running_reg;

`ifdef STOPWATCH_LAP_EN
    logic             lap_ev;
    logic             lap_active_reg;
    logic [SEC_W-1:0] lap_sec_reg;
    logic [MIN_W-1:0] lap_min_reg;
    assign lap_ev = ev_rise[4];
`else
    logic unused_lap;
    assign unused_lap = bus.lap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= SW_IDLE;
            ms_reg      <= '0;
            sec_reg     <= '0;
            min_reg     <= '0;
            running_reg <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_active_reg <= 1'b0;
            lap_sec_reg    <= '0;
            lap_min_reg    <= '0;
`endif
        end else if (bus.en) begin
            if (clear_ev) begin
                state_reg   <= SW_IDLE;
                ms_reg      <= '0;
                sec_reg     <= '0;
                min_reg     <= '0;
                running_reg <= 1'b0;
`ifdef STOPWATCH_LAP_EN
                lap_active_reg <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    SW_IDLE, SW_PAUSED: begin
                        // Simultaneous start+stop cancels out; a coincident tick is not counted.
                        if (start_ev && !stop_ev) begin
                            state_reg   <= SW_RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    SW_RUN: begin
                        if (stop_ev) begin
                            state_reg   <= SW_PAUSED;
                            running_reg <= 1'b0;
                        end else if (tick_ev) begin
                            if (ms_reg == MS_LAST) begin
                                ms_reg <= '0;
                                if (sec_reg == SEC_LAST) begin
                                    // Saturate at MAX_MIN:59 rather than wrapping the display.
                                    if (min_reg == MIN_LAST) begin
                                        state_reg   <= SW_MAXED;
                                        running_reg <= 1'b0;
                                    end else begin
                                        sec_reg <= '0;
                                        min_reg <= min_reg + 1'b1;
                                    end
                                end else begin
                                    sec_reg <= sec_reg + 1'b1;
                                end
                            end else begin
                                ms_reg <= ms_reg + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
`ifdef STOPWATCH_LAP_EN
                // Lap toggles only in RUN; elsewhere it can only release an active hold.
                if (lap_ev) begin
                    if (lap_active_reg) begin
                        lap_active_reg <= 1'b0;
                    end else if (state_reg == SW_RUN) begin
                        lap_active_reg <= 1'b1;
                        lap_sec_reg    <= sec_reg;
                        lap_min_reg    <= min_reg;
                    end
                end
`endif
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    assign bus.minutes    = lap_active_reg ? lap_min_reg : min_reg;
    assign bus.seconds    = lap_active_reg ? lap_sec_reg : sec_reg;
    assign bus.lap_active = lap_active_reg;
`else
    assign bus.minutes    = min_reg;
    assign bus.seconds    = sec_reg;
    assign bus.lap_active = 1'b0;
`endif
    assign bus.running = running_reg;

endmodule
